// File: rtl/dii_package.sv
// Debug Interconnect Interface flit type shared by all DII modules.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_dii_pkt_buffer_pkg.sv
// Local types and helpers for the DII store-and-forward packet buffer.
package osd_dii_pkt_buffer_pkg;

    import dii_package::*;

    localparam int unsigned FLIT_DATA_W = 16;
    localparam int unsigned ENTRY_W     = FLIT_DATA_W + 1;

    // One storage entry; the valid bit is implied by occupancy.
    typedef struct packed {
        logic                   last;
        logic [FLIT_DATA_W-1:0] data;
    } buf_entry_t;

    function automatic buf_entry_t flit_to_entry(input dii_flit f);
        buf_entry_t e;
        e.last = f.last;
        e.data = f.data;
        return e;
    endfunction

endpackage

// File: rtl/osd_dii_buffer_mem.sv
// DEPTH x WIDTH flit storage: one synchronous write port, one asynchronous read port.
module osd_dii_buffer_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/osd_dii_pkt_buffer.sv
// Store-and-forward DII packet buffer in front of the MAM debug_in port,
// with a full-buffer cut-through fallback for packets longer than DEPTH.
module osd_dii_pkt_buffer
    import dii_package::*;
    import osd_dii_pkt_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter bit          FULLPACKET = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  dii_flit                flit_in,
    output logic                   flit_in_ready,
    output dii_flit                flit_out,
    input  logic                   flit_out_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [$clog2(DEPTH):0] pkt_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic [PW-1:0] wr_ptr_r, rd_ptr_r, fill_r, pkt_cnt_r;
    logic [PW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s, fill_nxt_s, pkt_cnt_nxt_s;
    logic          cut_active_r, cut_active_nxt_s;
    logic          cut_last_wr_r, cut_last_wr_nxt_s;
    logic          full_s, empty_s, wr_s, rd_s, out_valid_s;
    logic          cut_set_s, cut_clr_s, consume_s, pkt_inc_s, pkt_dec_s;
    buf_entry_t    head_s;

    osd_dii_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (flit_to_entry(flit_in)),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (head_s)
    );

    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // Release gate: complete packet stored, or forced out by full/cut-through.
    assign out_valid_s = !empty_s && (!FULLPACKET || (pkt_cnt_r != '0) || full_s || cut_active_r);

    assign flit_in_ready = !full_s;
    assign wr_s          = flit_in.valid && !full_s;
    assign rd_s          = out_valid_s && flit_out_ready;

    assign flit_out.valid = out_valid_s;
    assign flit_out.last  = head_s.last;
    assign flit_out.data  = head_s.data;
    assign fill_level     = fill_r;
    assign pkt_count      = pkt_cnt_r;

    // A partial packet leaving with nothing counted starts a cut; its last flit ends it.
    // While the cut packet's last flit has not yet been written, that flit must not be counted.
    assign cut_clr_s = rd_s && head_s.last;
    assign cut_set_s = rd_s && !head_s.last && (pkt_cnt_r == '0);
    assign consume_s = (cut_active_r || cut_set_s) && !cut_last_wr_r;
    assign pkt_inc_s = wr_s && flit_in.last && !consume_s;
    assign pkt_dec_s = rd_s && head_s.last && !cut_active_r && (pkt_cnt_r != '0);

    // Next-state for pointers, counters and cut-through tracking.
    always_comb begin
        wr_ptr_nxt_s      = wr_ptr_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        fill_nxt_s        = fill_r;
        pkt_cnt_nxt_s     = pkt_cnt_r;
        cut_active_nxt_s  = cut_active_r;
        cut_last_wr_nxt_s = cut_last_wr_r;

        if (wr_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rd_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({wr_s, rd_s})
            2'b10:   fill_nxt_s = fill_r + PTR_ONE;
            2'b01:   fill_nxt_s = fill_r - PTR_ONE;
            default: fill_nxt_s = fill_r;
        endcase

        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + PTR_ONE;
            2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - PTR_ONE;
            default: pkt_cnt_nxt_s = pkt_cnt_r;
        endcase

        if (cut_clr_s) begin
            cut_active_nxt_s = 1'b0;
        end else if (cut_set_s) begin
            cut_active_nxt_s = 1'b1;
        end else begin
            cut_active_nxt_s = cut_active_r;
        end

        if (cut_clr_s) begin
            cut_last_wr_nxt_s = 1'b0;
        end else if (consume_s && wr_s && flit_in.last) begin
            cut_last_wr_nxt_s = 1'b1;
        end else begin
            cut_last_wr_nxt_s = cut_last_wr_r;
        end
    end

    // State registers; reset discards all stored flits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            fill_r        <= '0;
            pkt_cnt_r     <= '0;
            cut_active_r  <= 1'b0;
            cut_last_wr_r <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            fill_r        <= fill_nxt_s;
            pkt_cnt_r     <= pkt_cnt_nxt_s;
            cut_active_r  <= cut_active_nxt_s;
            cut_last_wr_r <= cut_last_wr_nxt_s;
        end
    end

endmodule

// File: tb/tb_osd_dii_pkt_buffer.sv
// Directed, table-driven bench for osd_dii_pkt_buffer across three configurations.
module tb_osd_dii_pkt_buffer;
    import dii_package::*;

    typedef struct {
        int          dut;
        logic        v;
        logic        l;
        logic [15:0] d;
        logic        ordy;
        logic        exp_ov;
        logic [15:0] exp_d;
        logic        exp_last;
        logic        exp_ir;
        logic [4:0]  exp_fill;
        logic [4:0]  exp_pkt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    dii_flit    fin  [3];
    dii_flit    fout [3];
    logic       ordy [3];
    logic       irdy [3];
    logic [4:0] fl_a, pk_a, fl_b, pk_b;
    logic [2:0] fl_c, pk_c;
    int         n_checks = 0;
    int         n_fail = 0;
    vec_t       tab[$];

    always #5 clk = ~clk;

    osd_dii_pkt_buffer #(.DEPTH(16), .FULLPACKET(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flit_in(fin[0]), .flit_in_ready(irdy[0]),
        .flit_out(fout[0]), .flit_out_ready(ordy[0]), .fill_level(fl_a), .pkt_count(pk_a));

    osd_dii_pkt_buffer #(.DEPTH(16), .FULLPACKET(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flit_in(fin[1]), .flit_in_ready(irdy[1]),
        .flit_out(fout[1]), .flit_out_ready(ordy[1]), .fill_level(fl_b), .pkt_count(pk_b));

    osd_dii_pkt_buffer #(.DEPTH(4), .FULLPACKET(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flit_in(fin[2]), .flit_in_ready(irdy[2]),
        .flit_out(fout[2]), .flit_out_ready(ordy[2]), .fill_level(fl_c), .pkt_count(pk_c));

    function automatic vec_t mk(int dut, logic v, logic l, logic [15:0] d, logic ordy_v,
                                logic eov, logic [15:0] ed, logic el, logic eir,
                                logic [4:0] ef, logic [4:0] ep);
        vec_t r;
        r.dut = dut; r.v = v; r.l = l; r.d = d; r.ordy = ordy_v;
        r.exp_ov = eov; r.exp_d = ed; r.exp_last = el; r.exp_ir = eir;
        r.exp_fill = ef; r.exp_pkt = ep;
        return r;
    endfunction

    function automatic logic [4:0] get_fill(int d);
        case (d)
            0:       return fl_a;
            1:       return fl_b;
            default: return {2'b00, fl_c};
        endcase
    endfunction

    function automatic logic [4:0] get_pkt(int d);
        case (d)
            0:       return pk_a;
            1:       return pk_b;
            default: return {2'b00, pk_c};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, check outputs 1 ns later.
    task automatic run_vec(vec_t t, string tag, int idx);
        @(negedge clk);
        fin[t.dut].valid = t.v;
        fin[t.dut].last  = t.l;
        fin[t.dut].data  = t.d;
        ordy[t.dut]      = t.ordy;
        #1;
        chk($sformatf("%s[%0d].valid", tag, idx), {31'd0, fout[t.dut].valid}, {31'd0, t.exp_ov});
        chk($sformatf("%s[%0d].in_ready", tag, idx), {31'd0, irdy[t.dut]}, {31'd0, t.exp_ir});
        chk($sformatf("%s[%0d].fill", tag, idx), {27'd0, get_fill(t.dut)}, {27'd0, t.exp_fill});
        chk($sformatf("%s[%0d].pkt", tag, idx), {27'd0, get_pkt(t.dut)}, {27'd0, t.exp_pkt});
        if (t.exp_ov) begin
            chk($sformatf("%s[%0d].data", tag, idx), {16'd0, fout[t.dut].data}, {16'd0, t.exp_d});
            chk($sformatf("%s[%0d].last", tag, idx), {31'd0, fout[t.dut].last}, {31'd0, t.exp_last});
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            fin[i] = '0;
            ordy[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Store-and-forward, DEPTH=16.
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        tab.push_back(mk(0, 1'b1, 1'b0, 16'hA001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        tab.push_back(mk(0, 1'b1, 1'b0, 16'hA002, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1, 5'd0));
        tab.push_back(mk(0, 1'b1, 1'b1, 16'hA003, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd2, 5'd0));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA001, 1'b0, 1'b1, 5'd3, 5'd1));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b0, 1'b1, 5'd2, 5'd1));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA003, 1'b1, 1'b1, 5'd1, 5'd1));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        // Back-pressure: two packets held for 10 cycles, then drained.
        tab.push_back(mk(0, 1'b1, 1'b0, 16'hB001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        tab.push_back(mk(0, 1'b1, 1'b1, 16'hB002, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1, 5'd0));
        tab.push_back(mk(0, 1'b1, 1'b1, 16'hC001, 1'b0, 1'b1, 16'hB001, 1'b0, 1'b1, 5'd2, 5'd1));
        for (int i = 0; i < 10; i++)
            tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB001, 1'b0, 1'b1, 5'd3, 5'd2));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB001, 1'b0, 1'b1, 5'd3, 5'd2));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB002, 1'b1, 1'b1, 5'd2, 5'd2));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC001, 1'b1, 1'b1, 5'd1, 5'd1));
        tab.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        // Full fallback, DEPTH=4: 6-flit packet 0..5.
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd2, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd3, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd4, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 5'd3, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1, 5'd3, 5'd0));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 5'd3, 5'd0));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 5'd2, 5'd0));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 5'd1, 5'd0));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        // Simultaneous read/write at full, DEPTH=4, two 2-flit packets.
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b1, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1, 5'd0));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0021, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 5'd2, 5'd1));
        tab.push_back(mk(2, 1'b1, 1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 5'd3, 5'd1));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0031, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 5'd4, 5'd2));
        tab.push_back(mk(2, 1'b1, 1'b0, 16'h0031, 1'b1, 1'b1, 16'h0012, 1'b1, 1'b1, 5'd3, 5'd2));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0021, 1'b0, 1'b1, 5'd3, 5'd1));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 1'b1, 1'b1, 5'd2, 5'd1));
        tab.push_back(mk(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1, 5'd0));

        for (int i = 0; i < tab.size(); i++)
            run_vec(tab[i], "tab", i);

        // Cut-through mode: partial flit visible next cycle; its last flit is not counted.
        run_vec(mk(1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "cut", 0);
        run_vec(mk(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 5'd1, 5'd0), "cut", 1);
        run_vec(mk(1, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "cut", 2);
        run_vec(mk(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b1, 5'd1, 5'd0), "cut", 3);
        run_vec(mk(1, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "cut", 4);
        run_vec(mk(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b1, 5'd1, 5'd1), "cut", 5);
        run_vec(mk(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "cut", 6);

        // Reset mid-packet: two of three flits stored in A and B.
        @(negedge clk);
        fin[0] = '{valid: 1'b1, last: 1'b0, data: 16'hD001}; ordy[0] = 1'b0;
        fin[1] = '{valid: 1'b1, last: 1'b0, data: 16'hD001}; ordy[1] = 1'b0;
        @(negedge clk);
        fin[0].data = 16'hD002;
        fin[1].data = 16'hD002;
        @(negedge clk);
        fin[0] = '0;
        fin[1] = '0;
        #1;
        chk("rst_pre.b_valid", {31'd0, fout[1].valid}, 32'd1);
        chk("rst_pre.b_data", {16'd0, fout[1].data}, 32'h0000_D001);
        chk("rst_pre.a_fill", {27'd0, fl_a}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst.b_valid", {31'd0, fout[1].valid}, 32'd0);
        chk("rst.b_fill", {27'd0, fl_b}, 32'd0);
        chk("rst.a_fill", {27'd0, fl_a}, 32'd0);
        chk("rst.a_pkt", {27'd0, pk_a}, 32'd0);
        chk("rst.c_fill", {29'd0, fl_c}, 32'd0);
        chk("rst.c_ready", {31'd0, irdy[2]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "post_rst_b", 0);
        run_vec(mk(0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "beef", 0);
        run_vec(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 5'd1, 5'd1), "beef", 1);
        run_vec(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 5'd0), "beef", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
